unidade_multdiv: RTL and testbench
==================================

Name: unidade_multdiv

Overview:
- Sequential multi-cycle multiply/divide unit that owns the HI/LO register pair.
- It is the other end of the combinational ALU's HI/LO path: it accepts an operation request from the control unit, iterates for 32 cycles, then holds results for mfhi/mflo-style reads and accepts mthi/mtlo-style writes.
- Unsigned arithmetic, matching the ALU's existing multiply, divide and remainder semantics.

Parameters:
- LARGURA, 32, operand width; HI/LO are each LARGURA bits; the iteration count equals LARGURA.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inicio  in  1  start request; sampled only in OCIOSO.
- operacao  in  1  0 = multiply, 1 = divide.
- RS  in  LARGURA  first operand (multiplicand / dividend).
- RT  in  LARGURA  second operand (multiplier / divisor).
- escreveHI  in  1  load HI from dadoEscrita.
- escreveLO  in  1  load LO from dadoEscrita.
- dadoEscrita  in  LARGURA  data for HI/LO writes.
- ocupado  out  1  operation in progress.
- pronto  out  1  one-cycle pulse when results are committed.
- erroDivZero  out  1  set by divide-by-zero; cleared by the next accepted inicio or by reset.
- saidaHI  out  LARGURA  HI register (multiply upper half / remainder).
- saidaLO  out  LARGURA  LO register (multiply lower half / quotient).

Behaviour:
- Reset (reset=0, asynchronous): state=OCIOSO, counter=0, ocupado=0, pronto=0, erroDivZero=0, saidaHI=0, saidaLO=0, working registers=0.
- Reset mid-operation aborts immediately; no partial result is ever committed.
- FSM states: OCIOSO, MULT, DIV.
- OCIOSO, inicio=1, operacao=0 at edge k:
  - latch RS and RT; clear the product accumulator; counter=0.
  - state=MULT; erroDivZero=0.
- OCIOSO, inicio=1, operacao=1, RT!=0 at edge k:
  - latch operands; clear the partial remainder; counter=0.
  - state=DIV; erroDivZero=0.
- OCIOSO, inicio=1, operacao=1, RT==0 at edge k:
  - no iteration; stay in OCIOSO.
  - at edge k: saidaLO={LARGURA{1'b1}}, saidaHI=RS, erroDivZero=1, pronto=1.
  - total latency is 1 cycle.
- MULT: shift-add, one multiplier bit per cycle (LSB first), using a 2*LARGURA accumulator.
- DIV: restoring division, one quotient bit per cycle (MSB first), with a LARGURA+1 bit trial subtraction.
- Iteration cycles occur at edges k+1 .. k+LARGURA.
- At edge k+LARGURA:
  - commit the result: MULT gives HI = product[2L-1:L], LO = product[L-1:0]; DIV gives LO = quotient, HI = remainder.
  - pronto=1; state=OCIOSO.
- Latency is LARGURA cycles from accepting inicio to pronto.
- ocupado = (state != OCIOSO); it is registered by construction from the state.
- pronto is high for exactly one cycle, then returns to 0.
- A new inicio is accepted in the same cycle pronto is high, since the state is already OCIOSO.
- inicio while ocupado=1 is ignored; no queuing, no restart.
- escreveHI / escreveLO:
  - honoured only in OCIOSO when inicio=0.
  - if both are asserted, both registers load dadoEscrita.
  - ignored while ocupado=1.
  - if inicio and a write coincide, inicio wins and the write is dropped.
- saidaHI/saidaLO hold their value between commits and writes; they change only at a commit, a write, or reset.
- Operand inputs may change freely after the accept edge; only latched copies are used.

Decomposition:
- Package multdiv_pkg holds:
  - state encodings: OCIOSO=2'b00, MULT=2'b01, DIV=2'b10.
  - operation codes: OP_MULT=1'b0, OP_DIV=1'b1.
  - the LARGURA default.
- One sub-module, passo_divisao: a combinational single restoring-division step.
  - inputs: partial remainder, next dividend bit, divisor.
  - outputs: new remainder, quotient bit.
  - instantiated once in unidade_multdiv.

Test Plan:
- Multiply: inicio, op=0, RS=0xFFFFFFFF, RT=0xFFFFFFFF -> after 32 cycles pronto pulses once; saidaHI=0xFFFFFFFE, saidaLO=0x00000001; ocupado high for exactly 32 cycles.
- Divide: op=1, RS=100, RT=7 -> at cycle 32 saidaLO=14, saidaHI=2, erroDivZero=0; also RS=5, RT=9 -> LO=0, HI=5.
- Divide by zero: op=1, RS=5, RT=0 -> on the next cycle pronto=1, saidaLO=0xFFFFFFFF, saidaHI=5, erroDivZero=1, ocupado never asserted; a following valid inicio clears erroDivZero.
- Busy protocol: while a multiply is running, pulse inicio with different operands and escreveHI=1 with dadoEscrita=0xDEAD -> both ignored; the original multiply result is committed; back-to-back inicio on the pronto cycle is accepted.
- Reset mid-operation: drive reset=0 at iteration 10 of a divide -> outputs go to 0 immediately (asynchronously) and the state is OCIOSO; after release, 12/4 gives LO=3, HI=0.
- HI/LO writes: in idle, escreveLO=1 with 0x1234 -> saidaLO=0x1234 and saidaHI unchanged; inicio and escreveHI in the same cycle -> the write is dropped.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit: width default,
// FSM state encodings and operation codes.
package multdiv_pkg;
    localparam int LARGURA_PADRAO = 32;

    localparam logic [1:0] OCIOSO = 2'b00;
    localparam logic [1:0] MULT   = 2'b01;
    localparam logic [1:0] DIV    = 2'b10;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;
endpackage

// File: rtl/unidade_multdiv_passo_divisao.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module passo_divisao #(
    parameter int LARGURA = 32
) (
    input  logic [LARGURA-1:0] resto,
    input  logic               bit_dividendo,
    input  logic [LARGURA-1:0] divisor,
    output logic [LARGURA-1:0] resto_novo,
    output logic               bit_quociente
);
    logic [LARGURA:0]   deslocado;
    logic [LARGURA-1:0] diferenca;

    // resto < divisor on entry, so any successful difference fits in LARGURA bits
    // and the modular subtraction below is exact.
    assign deslocado     = {resto, bit_dividendo};
    assign bit_quociente = (deslocado >= {1'b0, divisor});
    assign diferenca     = deslocado[LARGURA-1:0] - divisor;
    assign resto_novo    = bit_quociente ? diferenca : deslocado[LARGURA-1:0];
endmodule

// File: rtl/unidade_multdiv.sv
// Sequential unsigned multiply/divide unit owning HI/LO. Start requests are
// taken only in OCIOSO; results commit after LARGURA iterations with a one-cycle pronto.
module unidade_multdiv
    import multdiv_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic               operacao,
    input  logic [LARGURA-1:0] RS,
    input  logic [LARGURA-1:0] RT,
    input  logic               escreveHI,
    input  logic               escreveLO,
    input  logic [LARGURA-1:0] dadoEscrita,
    output logic               ocupado,
    output logic               pronto,
    output logic               erroDivZero,
    output logic [LARGURA-1:0] saidaHI,
    output logic [LARGURA-1:0] saidaLO,
    output logic [1:0]         estado_dbg
);
    localparam int CONT_W = $clog2(LARGURA);
    localparam logic [CONT_W-1:0] ULTIMO = CONT_W'(LARGURA - 1);

    logic [1:0]           estado;
    logic [CONT_W-1:0]    contador;
    logic [LARGURA-1:0]   operando;
    // MULT: {partial product high, remaining multiplier bits}
    // DIV:  {partial remainder, dividend bits shifting into quotient}
    logic [2*LARGURA-1:0] acc;

    logic [LARGURA:0]     soma;
    logic [2*LARGURA-1:0] acc_mult;
    logic [LARGURA-1:0]   resto_novo;
    logic                 bit_q;
    logic [2*LARGURA-1:0] acc_div;

    assign soma     = {1'b0, acc[2*LARGURA-1:LARGURA]} + {1'b0, operando & {LARGURA{acc[0]}}};
    assign acc_mult = {soma, acc[LARGURA-1:1]};

    passo_divisao #(.LARGURA(LARGURA)) u_passo (
        .resto        (acc[2*LARGURA-1:LARGURA]),
        .bit_dividendo(acc[LARGURA-1]),
        .divisor      (operando),
        .resto_novo   (resto_novo),
        .bit_quociente(bit_q)
    );

    assign acc_div = {resto_novo, acc[LARGURA-2:0], bit_q};

    assign ocupado    = (estado != OCIOSO);
    assign estado_dbg = estado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= OCIOSO;
            contador    <= '0;
            operando    <= '0;
            acc         <= '0;
            pronto      <= 1'b0;
            erroDivZero <= 1'b0;
            saidaHI     <= '0;
            saidaLO     <= '0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        if (operacao == OP_MULT) begin
                            operando    <= RS;
                            acc         <= {{LARGURA{1'b0}}, RT};
                            contador    <= '0;
                            estado      <= MULT;
                            erroDivZero <= 1'b0;
                        end else if (RT != '0) begin
                            operando    <= RT;
                            acc         <= {{LARGURA{1'b0}}, RS};
                            contador    <= '0;
                            estado      <= DIV;
                            erroDivZero <= 1'b0;
                        end else begin
                            saidaLO     <= {LARGURA{1'b1}};
                            saidaHI     <= RS;
                            erroDivZero <= 1'b1;
                            pronto      <= 1'b1;
                        end
                    end else begin
                        if (escreveHI) saidaHI <= dadoEscrita;
                        if (escreveLO) saidaLO <= dadoEscrita;
                    end
                end
                MULT: begin
                    acc      <= acc_mult;
                    contador <= contador + 1'b1;
                    if (contador == ULTIMO) begin
                        saidaHI <= acc_mult[2*LARGURA-1:LARGURA];
                        saidaLO <= acc_mult[LARGURA-1:0];
                        pronto  <= 1'b1;
                        estado  <= OCIOSO;
                    end
                end
                DIV: begin
                    acc      <= acc_div;
                    contador <= contador + 1'b1;
                    if (contador == ULTIMO) begin
                        saidaHI <= acc_div[2*LARGURA-1:LARGURA];
                        saidaLO <= acc_div[LARGURA-1:0];
                        pronto  <= 1'b1;
                        estado  <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_unidade_multdiv.sv
// Directed bench for unidade_multdiv: expected HI/LO pairs are queued when an
// operation is started and popped when pronto is seen.
module tb_unidade_multdiv;
    localparam int L = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         inicio;
    logic         operacao;
    logic [L-1:0] RS;
    logic [L-1:0] RT;
    logic         escreveHI;
    logic         escreveLO;
    logic [L-1:0] dadoEscrita;
    logic         ocupado;
    logic         pronto;
    logic         erroDivZero;
    logic [L-1:0] saidaHI;
    logic [L-1:0] saidaLO;
    logic [1:0]   estado_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*L-1:0] exp_q[$];

    unidade_multdiv #(.LARGURA(L)) dut (
        .clock      (clock),
        .reset      (reset),
        .inicio     (inicio),
        .operacao   (operacao),
        .RS         (RS),
        .RT         (RT),
        .escreveHI  (escreveHI),
        .escreveLO  (escreveLO),
        .dadoEscrita(dadoEscrita),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .erroDivZero(erroDivZero),
        .saidaHI    (saidaHI),
        .saidaLO    (saidaLO),
        .estado_dbg (estado_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [2*L-1:0] obs, input logic [2*L-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start request at a falling edge; it is accepted at the next rising edge.
    task automatic start_op(input logic op, input logic [L-1:0] a, input logic [L-1:0] b);
        logic [2*L-1:0] e;
        if (op == 1'b0)      e = {32'd0, a} * {32'd0, b};
        else if (b == '0)    e = {a, {L{1'b1}}};
        else                 e = {a % b, a / b};
        exp_q.push_back(e);
        inicio = 1'b1; operacao = op; RS = a; RT = b;
        @(negedge clock);
        inicio = 1'b0; RS = $urandom; RT = $urandom;
    endtask

    // Wait for pronto; ja = edges already elapsed since accept, lat = expected latency.
    task automatic esperar(input string tag, input int ja, input int lat, input logic erro_esp);
        int ciclos;
        int ocup;
        logic [2*L-1:0] e;
        ciclos = ja;
        ocup   = 0;
        while (pronto !== 1'b1 && ciclos < 40) begin
            if (ocupado === 1'b1) ocup++;
            @(negedge clock);
            ciclos++;
        end
        check({tag, "_pronto_seen"}, {63'd0, pronto}, 64'd1);
        check({tag, "_latency"}, 64'(ciclos), 64'(lat));
        check({tag, "_ocupado_cycles"}, 64'(ocup), 64'(lat - ja));
        check({tag, "_ocupado_at_pronto"}, {63'd0, ocupado}, 64'd0);
        check({tag, "_erro"}, {63'd0, erroDivZero}, {63'd0, erro_esp});
        if (exp_q.size() == 0) begin
            check({tag, "_queue_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, {32'd0, saidaHI}, {32'd0, e[2*L-1:L]});
            check({tag, "_lo"}, {32'd0, saidaLO}, {32'd0, e[L-1:0]});
        end
    endtask

    initial begin
        reset = 1'b0; inicio = 1'b0; operacao = 1'b0; RS = '0; RT = '0;
        escreveHI = 1'b0; escreveLO = 1'b0; dadoEscrita = '0;
        repeat (2) @(negedge clock);
        check("rst_ocupado", {63'd0, ocupado}, 64'd0);
        check("rst_pronto", {63'd0, pronto}, 64'd0);
        check("rst_erro", {63'd0, erroDivZero}, 64'd0);
        check("rst_hi", {32'd0, saidaHI}, 64'd0);
        check("rst_lo", {32'd0, saidaLO}, 64'd0);
        check("rst_estado", {62'd0, estado_dbg}, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Full-scale multiply
        start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        esperar("mult_max", 0, 32, 1'b0);
        @(negedge clock);
        check("mult_pronto_one_cycle", {63'd0, pronto}, 64'd0);

        // Busy: inicio and escreveHI mid-operation are ignored
        start_op(1'b0, 32'd12345, 32'd678);
        repeat (5) @(negedge clock);
        inicio = 1'b1; operacao = 1'b1; RS = 32'd99; RT = 32'd3;
        escreveHI = 1'b1; dadoEscrita = 32'hDEAD;
        @(negedge clock);
        inicio = 1'b0; escreveHI = 1'b0;
        esperar("busy_mult", 6, 32, 1'b0);
        // Back-to-back start on the pronto cycle
        start_op(1'b1, 32'd100, 32'd7);
        esperar("div_100_7", 0, 32, 1'b0);
        start_op(1'b1, 32'd5, 32'd9);
        esperar("div_5_9", 0, 32, 1'b0);
        @(negedge clock);

        // Divide by zero, then a valid start clears the flag
        start_op(1'b1, 32'd5, 32'd0);
        esperar("divzero", 0, 0, 1'b1);
        @(negedge clock);
        check("divzero_pronto_one_cycle", {63'd0, pronto}, 64'd0);
        check("divzero_erro_held", {63'd0, erroDivZero}, 64'd1);
        start_op(1'b0, 32'd7, 32'd6);
        check("erro_cleared", {63'd0, erroDivZero}, 64'd0);
        esperar("mult_7_6", 0, 32, 1'b0);
        @(negedge clock);

        // Random divide
        start_op(1'b1, $urandom, 32'($urandom_range(1, 1000)));
        esperar("div_rand", 0, 32, 1'b0);
        @(negedge clock);

        // Reset during iteration 10 of a divide
        start_op(1'b1, 32'd1000, 32'd3);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_ocupado", {63'd0, ocupado}, 64'd0);
        check("midrst_estado", {62'd0, estado_dbg}, 64'd0);
        check("midrst_hi", {32'd0, saidaHI}, 64'd0);
        check("midrst_lo", {32'd0, saidaLO}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        start_op(1'b1, 32'd12, 32'd4);
        esperar("div_12_4", 0, 32, 1'b0);
        @(negedge clock);

        // Idle writes
        escreveLO = 1'b1; dadoEscrita = 32'h1234;
        @(negedge clock);
        escreveLO = 1'b0;
        check("wr_lo", {32'd0, saidaLO}, 64'h1234);
        check("wr_lo_hi_unchanged", {32'd0, saidaHI}, 64'd0);
        escreveHI = 1'b1; escreveLO = 1'b1; dadoEscrita = 32'hCAFE;
        @(negedge clock);
        escreveHI = 1'b0; escreveLO = 1'b0;
        check("wr_both_hi", {32'd0, saidaHI}, 64'hCAFE);
        check("wr_both_lo", {32'd0, saidaLO}, 64'hCAFE);
        // inicio wins over a coincident write
        escreveHI = 1'b1; dadoEscrita = 32'hBEEF;
        start_op(1'b0, 32'd2, 32'd3);
        escreveHI = 1'b0;
        check("wr_dropped_hi", {32'd0, saidaHI}, 64'hCAFE);
        check("wr_dropped_busy", {63'd0, ocupado}, 64'd1);
        esperar("mult_2_3", 0, 32, 1'b0);
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
